// File: rtl/display_pkg.sv
// Glyph and enable constants shared by the seven-segment scan path.
// Segment vectors are active-low, ordered {g,f,e,d,c,b,a}.
package display_pkg;
    localparam int IDX_W = 2;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [3:0] AN_OFF   = 4'b1111;
endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decode; non-BCD values show a dash.
module bcd_to_seg7
    import display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_DASH;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/score_display_scan.sv
// Four-digit common-anode scan driver with frame-coherent snapshot,
// leading-zero blanking and whole-display blink.
module score_display_scan
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_TICKS = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] thousands,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       blank_lz,
    input  logic       blink_en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic [PW-1:0]        pcnt;
    logic [IDX_W-1:0]     idx;
    logic [BW-1:0]        bcnt;
    logic                 phase;
    logic                 load_pend;
    logic [3:0][3:0]      snap;

    logic                 tick;
    logic                 load;
    logic [3:0]           cur_digit;
    logic [6:0]           dec_seg;
    logic                 blanked;
    logic [3:0]           an_d;
    logic [6:0]           seg_d;

    assign tick      = (pcnt == PW'(REFRESH_DIV - 1));
    // Snapshot only at the frame boundary (or right after reset) so a frame never mixes two scores.
    assign load      = load_pend | (tick & (idx == IDX_W'(3)));
    assign cur_digit = snap[idx];

    bcd_to_seg7 u_dec (
        .digit (cur_digit),
        .seg   (dec_seg)
    );

    always_comb begin
        blanked = 1'b0;
        case (idx)
            2'd3:    blanked = (snap[3] == 4'd0);
            2'd2:    blanked = (snap[3] == 4'd0) && (snap[2] == 4'd0);
            2'd1:    blanked = (snap[3] == 4'd0) && (snap[2] == 4'd0) && (snap[1] == 4'd0);
            default: blanked = 1'b0;
        endcase
        blanked = blanked & blank_lz;

        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        if (phase && !blanked) begin
            an_d  = ~(4'b0001 << idx);
            seg_d = dec_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt        <= '0;
            idx         <= '0;
            bcnt        <= '0;
            phase       <= 1'b1;
            load_pend   <= 1'b1;
            snap        <= '0;
            frame_start <= 1'b0;
            an          <= AN_OFF;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
        end else begin
            pcnt <= tick ? '0 : pcnt + PW'(1);
            if (tick)
                idx <= idx + IDX_W'(1);

            if (load) begin
                snap      <= {thousands, hundreds, tens, ones};
                load_pend <= 1'b0;
            end
            frame_start <= load;

            if (!blink_en) begin
                bcnt  <= '0;
                phase <= 1'b1;
            end else if (tick) begin
                if (bcnt == BW'(BLINK_TICKS - 1)) begin
                    bcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    bcnt <= bcnt + BW'(1);
                end
            end

            an  <= an_d;
            seg <= seg_d;
            dp  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_score_display_scan.sv
// Scoreboard bench: stimulus queues per-slot {an,seg} expectations for whole frames;
// the monitor starts checking a frame at each frame_start pulse.
module tb_score_display_scan;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] thousands, hundreds, tens, ones;
    logic       blank_lz, blink_en;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp, frame_start;

    int checks   = 0;
    int failures = 0;
    logic [10:0] exp_q[$];

    score_display_scan #(.REFRESH_DIV(4), .BLINK_TICKS(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .thousands   (thousands),
        .hundreds    (hundreds),
        .tens        (tens),
        .ones        (ones),
        .blank_lz    (blank_lz),
        .blink_en    (blink_en),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push_slot(input logic [3:0] a, input logic [6:0] s);
        exp_q.push_back({a, s});
    endtask

    task automatic set_digits(input logic [3:0] d3, d2, d1, d0);
        thousands = d3; hundreds = d2; tens = d1; ones = d0;
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 200);
        if (!frame_start) begin
            checks++;
            failures++;
            $display("FAIL frame_start_timeout: no pulse within %0d cycles", n);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d expected slots left unchecked", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"},  32'(an),  32'h0000000f);
        check({tag, "_seg"}, 32'(seg), 32'h0000007f);
        check({tag, "_dp"},  32'(dp),  32'h1);
        check({tag, "_fs"},  32'(frame_start), 32'h0);
    endtask

    // Monitor: each slot is sampled mid-slot, two cycles after its first output cycle.
    initial begin
        int fr;
        logic [10:0] e;
        fr = 0;
        forever begin
            @(negedge clk);
            if (frame_start && exp_q.size() >= 4) begin
                for (int k = 0; k < 4; k++) begin
                    repeat (k == 0 ? 2 : 4) @(negedge clk);
                    e = exp_q.pop_front();
                    check($sformatf("frame%0d_slot%0d", fr, k), 32'({an, seg, dp}), 32'({e, 1'b1}));
                end
                fr++;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        blank_lz = 1'b0;
        blink_en = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Basic scan of 1,2,3,4: slot0 = ones
        push_slot(4'b1110, 7'b0011001);
        push_slot(4'b1101, 7'b0110000);
        push_slot(4'b1011, 7'b0100100);
        push_slot(4'b0111, 7'b1111001);
        rst_n = 1'b1;
        wait_drain();

        // Mid-frame change of ones: current frame keeps 4, next frame shows 7
        wait_frame();
        @(negedge clk);
        push_slot(4'b1110, 7'b0011001);
        push_slot(4'b1101, 7'b0110000);
        push_slot(4'b1011, 7'b0100100);
        push_slot(4'b0111, 7'b1111001);
        push_slot(4'b1110, 7'b1111000);
        push_slot(4'b1101, 7'b0110000);
        push_slot(4'b1011, 7'b0100100);
        push_slot(4'b0111, 7'b1111001);
        wait_frame();
        repeat (6) @(negedge clk);
        ones = 4'd7;
        wait_drain();

        // Leading-zero blanking: 0005 then 0000
        wait_frame();
        @(negedge clk);
        set_digits(4'd0, 4'd0, 4'd0, 4'd5);
        blank_lz = 1'b1;
        push_slot(4'b1110, 7'b0010010);
        push_slot(4'b1111, 7'b1111111);
        push_slot(4'b1111, 7'b1111111);
        push_slot(4'b1111, 7'b1111111);
        push_slot(4'b1110, 7'b1000000);
        push_slot(4'b1111, 7'b1111111);
        push_slot(4'b1111, 7'b1111111);
        push_slot(4'b1111, 7'b1111111);
        wait_frame();
        @(negedge clk);
        ones = 4'd0;
        wait_drain();

        // Out-of-range thousands digit shows a dash
        wait_frame();
        @(negedge clk);
        blank_lz = 1'b0;
        set_digits(4'hC, 4'd2, 4'd3, 4'd4);
        push_slot(4'b1110, 7'b0011001);
        push_slot(4'b1101, 7'b0110000);
        push_slot(4'b1011, 7'b0100100);
        push_slot(4'b0111, 7'b0111111);
        wait_drain();

        // Blink: 2 ticks on, 2 ticks off, aligned so slots 2,3 of each frame are dark
        wait_frame();
        @(negedge clk);
        blink_en = 1'b1;
        for (int f = 0; f < 2; f++) begin
            push_slot(4'b1110, 7'b0011001);
            push_slot(4'b1101, 7'b0110000);
            push_slot(4'b1111, 7'b1111111);
            push_slot(4'b1111, 7'b1111111);
        end
        wait_drain();

        // Drop blink_en during the dark phase; display returns
        wait_frame();
        repeat (10) @(negedge clk);
        check("blink_dark_an", 32'(an), 32'h0000000f);
        blink_en = 1'b0;
        repeat (2) @(negedge clk);
        check("blink_restore_an",  32'(an),  32'h0000000b);
        check("blink_restore_seg", 32'(seg), 32'h00000024);

        // One-cycle reset at idx=2, then fresh snapshot 5,6,7,8
        wait_frame();
        repeat (9) @(negedge clk);
        set_digits(4'd5, 4'd6, 4'd7, 4'd8);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        push_slot(4'b1110, 7'b0000000);
        push_slot(4'b1101, 7'b1111000);
        push_slot(4'b1011, 7'b0000010);
        push_slot(4'b0111, 7'b0010010);
        @(negedge clk);
        check("midreset_frame_start", 32'(frame_start), 32'h1);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
